// File: rtl/halflife_decay_driver.sv
// ---------------------------------------------------------------------------
// halflife_decay_driver
//
// Control-side driver for the half-life up/down/load counter. It loads an
// initial count into the counter, then after every programmable period issues
// a back-to-back burst of single-cycle down strobes. Each burst removes
// ceil(count/2), which leaves floor(count/2). Bursts repeat until the count
// reaches zero. A shadow copy of the counter value and the number of completed
// half-lives are kept and reported.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous reset, active-low
//   start     in   1   begin a run (only looked at in IDLE)
//   abort     in   1   cancel the run in progress (LOAD/WAIT/BURST only)
//   init      in   N   initial count, captured with start
//   period    in   PW  cycles per half-life, captured with start (0 acts as 1)
//   load      out  1   counter load strobe
//   up        out  1   counter up strobe, always 0
//   down      out  1   counter down strobe
//   ld_val    out  N   counter load value, 0 unless load=1
//   shadow    out  N   modelled counter value
//   halvings  out  N   completed half-lives in the current/last run
//   busy      out  1   high in LOAD, WAIT and BURST
//   done      out  1   one-cycle pulse when a run completes
// ---------------------------------------------------------------------------
module halflife_decay_driver #(
  parameter int N  = 4,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  init,
  input  logic [PW-1:0] period,
  output logic          load,
  output logic          up,
  output logic          down,
  output logic [N-1:0]  ld_val,
  output logic [N-1:0]  shadow,
  output logic [N-1:0]  halvings,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_BURST = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [N-1:0]  ZERO_N  = {N{1'b0}};
  localparam logic [N-1:0]  ONE_N   = N'(1'b1);
  localparam logic [PW-1:0] ZERO_PW = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_PW  = PW'(1'b1);

  // Number of down strobes that take v to floor(v/2).
  function automatic logic [N-1:0] ceil_half(input logic [N-1:0] v);
    return v - {1'b0, v[N-1:1]};
  endfunction

  state_t        state_r, state_s;
  logic [N-1:0]  init_r, init_s;
  logic [PW-1:0] period_r, period_s;
  logic [PW-1:0] timer_r, timer_s;
  logic [N-1:0]  remaining_r, remaining_s;
  logic [N-1:0]  shadow_r, shadow_s;
  logic [N-1:0]  halvings_r, halvings_s;
  logic          load_r, load_s;
  logic          down_r, down_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [N-1:0]  ld_val_r, ld_val_s;
  logic [PW-1:0] reload_s;

  // A zero period is stretched to one cycle so every WAIT lasts at least once.
  assign reload_s = (period_r == ZERO_PW) ? ONE_PW : period_r;

  // Next-state, datapath and strobe decode; strobes are derived from the next
  // state so that they can be flopped and appear in the state they belong to.
  always_comb begin
    state_s     = state_r;
    init_s      = init_r;
    period_s    = period_r;
    timer_s     = timer_r;
    remaining_s = remaining_r;
    shadow_s    = shadow_r;
    halvings_s  = halvings_r;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s    = S_LOAD;
          init_s     = init;
          period_s   = period;
          halvings_s = ZERO_N;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_LOAD: begin
        // The load strobe is already out this cycle, so the counter now holds
        // init even if the run is being aborted.
        shadow_s = init_r;
        if (abort) begin
          state_s = S_IDLE;
        end else if (init_r == ZERO_N) begin
          state_s = S_DONE;
        end else begin
          state_s = S_WAIT;
          timer_s = reload_s;
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (timer_r <= ONE_PW) begin
          remaining_s = ceil_half(shadow_r);
          state_s     = S_BURST;
        end else begin
          timer_s = timer_r - ONE_PW;
        end
      end

      S_BURST: begin
        // The down strobe of this cycle completes regardless of abort.
        shadow_s    = shadow_r - ONE_N;
        remaining_s = remaining_r - ONE_N;
        if (abort) begin
          state_s = S_IDLE;
        end else if (remaining_r <= ONE_N) begin
          halvings_s = halvings_r + ONE_N;
          if (shadow_r == ONE_N) begin
            state_s = S_DONE;
          end else begin
            state_s = S_WAIT;
            timer_s = reload_s;
          end
        end else begin
          state_s = S_BURST;
        end
      end

      S_DONE: begin
        state_s = S_IDLE;
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase

    load_s   = (state_s == S_LOAD);
    down_s   = (state_s == S_BURST);
    done_s   = (state_s == S_DONE);
    busy_s   = (state_s == S_LOAD) || (state_s == S_WAIT) || (state_s == S_BURST);
    ld_val_s = load_s ? init_s : ZERO_N;
  end

  // State, datapath and registered strobe outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      init_r      <= ZERO_N;
      period_r    <= ZERO_PW;
      timer_r     <= ZERO_PW;
      remaining_r <= ZERO_N;
      shadow_r    <= ZERO_N;
      halvings_r  <= ZERO_N;
      load_r      <= 1'b0;
      down_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ld_val_r    <= ZERO_N;
    end else begin
      state_r     <= state_s;
      init_r      <= init_s;
      period_r    <= period_s;
      timer_r     <= timer_s;
      remaining_r <= remaining_s;
      shadow_r    <= shadow_s;
      halvings_r  <= halvings_s;
      load_r      <= load_s;
      down_r      <= down_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      ld_val_r    <= ld_val_s;
    end
  end

  assign load     = load_r;
  assign up       = 1'b0;
  assign down     = down_r;
  assign ld_val   = ld_val_r;
  assign shadow   = shadow_r;
  assign halvings = halvings_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_halflife_decay_driver.sv
// ---------------------------------------------------------------------------
// tb_halflife_decay_driver
//
// Self-checking bench for halflife_decay_driver. A reference model builds the
// expected per-cycle activity of a run (load, wait, burst, done, idle) from
// plain arithmetic on the count, and every cycle of the DUT is compared with
// it. A table of directed runs also carries hand-computed totals, and random
// runs follow.
// ---------------------------------------------------------------------------
module tb_halflife_decay_driver;

  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int MAXC = 256;

  localparam int K_IDLE  = 0;
  localparam int K_LOAD  = 1;
  localparam int K_WAIT  = 2;
  localparam int K_BURST = 3;
  localparam int K_DONE  = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [N-1:0]  init;
  logic [PW-1:0] period;
  logic          load;
  logic          up;
  logic          down;
  logic [N-1:0]  ld_val;
  logic [N-1:0]  shadow;
  logic [N-1:0]  halvings;
  logic          busy;
  logic          done;

  int n_checks;
  int n_fail;

  int kind    [0:MAXC];
  int eshadow [0:MAXC];
  int ehalv   [0:MAXC];

  typedef struct {
    int ini;
    int per;
    int ab;       // abort cycle after start, 0 = none
    int tail;     // idle cycles checked after the run
    int downs;
    int halv;
    int shadow;
    int done_at;  // cycle of the done pulse, 0 = none
  } vec_t;

  vec_t tbl [7];

  halflife_decay_driver #(.N(N), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .init     (init),
    .period   (period),
    .load     (load),
    .up       (up),
    .down     (down),
    .ld_val   (ld_val),
    .shadow   (shadow),
    .halvings (halvings),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " load"},     32'(load),     32'd0);
    chk({tag, " up"},       32'(up),       32'd0);
    chk({tag, " down"},     32'(down),     32'd0);
    chk({tag, " ld_val"},   32'(ld_val),   32'd0);
    chk({tag, " shadow"},   32'(shadow),   32'd0);
    chk({tag, " halvings"}, 32'(halvings), 32'd0);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " done"},     32'(done),     32'd0);
  endtask

  // Reference model: lay out the run cycle by cycle. Cycle 1 is the load,
  // each half-life is max(period,1) wait cycles followed by ceil(s/2) downs.
  // eshadow/ehalv hold the values visible during each cycle.
  task automatic build_trace(input int ini, input int per, input int ab, output int last);
    int c;
    int s;
    int h;
    int p;
    int b;
    int hold_s;
    for (int i = 0; i <= MAXC; i++) begin
      kind[i]    = K_IDLE;
      eshadow[i] = 0;
      ehalv[i]   = 0;
    end
    s = ini;
    h = 0;
    kind[1]  = K_LOAD;
    ehalv[1] = 0;
    c = 2;
    p = (per == 0) ? 1 : per;
    while (s > 0) begin
      for (int j = 0; j < p; j++) begin
        kind[c] = K_WAIT; eshadow[c] = s; ehalv[c] = h; c++;
      end
      b = s - s / 2;
      for (int j = 0; j < b; j++) begin
        kind[c] = K_BURST; eshadow[c] = s; ehalv[c] = h; s--; c++;
      end
      h++;
    end
    kind[c] = K_DONE; eshadow[c] = s; ehalv[c] = h;
    last = c;
    if (ab > 0 && ab < last) begin
      if (ab == 1) hold_s = ini;
      else hold_s = eshadow[ab] - ((kind[ab] == K_BURST) ? 1 : 0);
      h = ehalv[ab];
      for (int t = ab + 1; t <= MAXC; t++) begin
        kind[t] = K_IDLE; eshadow[t] = hold_s; ehalv[t] = h;
      end
      last = ab;
    end else begin
      for (int t = c + 1; t <= MAXC; t++) begin
        eshadow[t] = s; ehalv[t] = h;
      end
    end
  endtask

  // Apply one run from an IDLE negedge and compare every cycle with the model.
  task automatic run_case(input int ini, input int per, input int ab, input int tail,
                          input bit has_exp, input vec_t v);
    int    last;
    int    downs;
    int    done_at;
    int    k;
    string tag;
    build_trace(ini, per, ab, last);
    init   = N'(ini);
    period = PW'(per);
    start  = 1'b1;
    abort  = 1'b0;
    downs   = 0;
    done_at = 0;
    for (int t = 1; t <= last + tail; t++) begin
      @(negedge clk);
      k   = kind[t];
      tag = $sformatf("run(%0d,%0d,ab%0d) t%0d", ini, per, ab, t);
      chk({tag, " load"},   32'(load),   32'(k == K_LOAD));
      chk({tag, " up"},     32'(up),     32'd0);
      chk({tag, " down"},   32'(down),   32'(k == K_BURST));
      chk({tag, " done"},   32'(done),   32'(k == K_DONE));
      chk({tag, " busy"},   32'(busy),   32'(k == K_LOAD || k == K_WAIT || k == K_BURST));
      chk({tag, " ld_val"}, 32'(ld_val), (k == K_LOAD) ? 32'(ini) : 32'd0);
      chk({tag, " halvings"}, 32'(halvings), 32'(ehalv[t]));
      if (t >= 2) chk({tag, " shadow"}, 32'(shadow), 32'(eshadow[t]));
      if (down === 1'b1) downs++;
      if (done === 1'b1 && done_at == 0) done_at = t;
      // Inputs for the edge that ends cycle t: start/init/period noise while
      // the run is busy or done must be ignored; stray abort only where harmless.
      if (t < last) begin
        start  = 1'($urandom_range(0, 1));
        init   = N'($urandom_range(0, 15));
        period = PW'($urandom_range(0, 7));
        abort  = (ab > 0 && t == ab) ? 1'b1 : 1'b0;
      end else if (t == last) begin
        start = 1'($urandom_range(0, 1));
        abort = (ab > 0 && t == ab) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
        abort = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (has_exp) begin
      tag = $sformatf("total(%0d,%0d,ab%0d)", ini, per, ab);
      chk({tag, " downs"},    32'(downs),    32'(v.downs));
      chk({tag, " halvings"}, 32'(halvings), 32'(v.halv));
      chk({tag, " shadow"},   32'(shadow),   32'(v.shadow));
      chk({tag, " done_at"},  32'(done_at),  32'(v.done_at));
    end
  endtask

  initial begin
    int   last;
    int   ab;
    int   ini;
    int   per;
    vec_t dummy;

    n_checks = 0;
    n_fail   = 0;
    dummy    = '{0, 0, 0, 0, 0, 0, 0, 0};

    //             ini per ab tail downs halv shadow done_at
    tbl[0] = '{ 8, 3, 0, 1,  8, 4,  0, 22};
    tbl[1] = '{ 0, 5, 0, 1,  0, 0,  0,  2};
    tbl[2] = '{15, 0, 0, 1, 15, 4,  0, 21};
    tbl[3] = '{12, 2, 5, 2,  2, 0, 10,  0};
    tbl[4] = '{ 1, 1, 0, 1,  1, 1,  0,  4};   // next run starts the cycle after done
    tbl[5] = '{ 5, 2, 0, 2,  5, 3,  0, 13};
    tbl[6] = '{ 3, 4, 1, 2,  0, 0,  3,  0};   // abort during the load cycle

    // Reset held with start asserted: everything stays quiet.
    rst    = 1'b0;
    start  = 1'b1;
    abort  = 1'b0;
    init   = N'(8);
    period = PW'(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_all_zero($sformatf("reset cyc%0d", i));
    end
    // Release; start (still high) is taken on the very next edge.
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_case(tbl[i].ini, tbl[i].per, tbl[i].ab, tbl[i].tail, 1'b1, tbl[i]);
    end

    // Reset in the middle of a run clears everything at once.
    init   = N'(9);
    period = PW'(1);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("midrun async reset");
    @(negedge clk);
    chk_all_zero("midrun reset held");
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("after midrun reset");

    // Random runs against the model.
    for (int r = 0; r < 40; r++) begin
      ini = $urandom_range(0, 15);
      per = $urandom_range(0, 4);
      build_trace(ini, per, 0, last);
      ab = 0;
      if (last > 2 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, last - 1);
      run_case(ini, per, ab, $urandom_range(1, 3), 1'b0, dummy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
